// File: rtl/dsp_mac_ctrl.sv
// Dot-product sequencer that feeds operands and per-beat OPMODE words to one DSP48A1 slice.
// Optional build macro DSP_MAC_ROUND_EN adds round-half-up via the C port and shifts the result.
module dsp_mac_ctrl #(
  parameter int unsigned TAPS      = 8,
  parameter int unsigned RND_SHIFT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [47:0] m_data,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [47:0] DSP_C,
  output logic [7:0]  DSP_OPMODE,
  output logic        DSP_CE,
  output logic        DSP_RST,
  input  logic [47:0] DSP_P
);

  localparam int unsigned     CW       = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0]   LAST_TAP = CW'(TAPS - 1);
  localparam logic [7:0]      OPM_TAP    = 8'b0000_1001;
  localparam logic [7:0]      OPM_BUBBLE = 8'b0000_1000;
`ifdef DSP_MAC_ROUND_EN
  localparam logic [7:0]      OPM_FIRST  = 8'b0000_1101;
`else
  localparam logic [7:0]      OPM_FIRST  = 8'b0000_0001;
`endif

  if (TAPS < 2 || TAPS > 256 || RND_SHIFT < 1 || RND_SHIFT > 35) begin : g_param_check
    $error("dsp_mac_ctrl: TAPS must be 2..256 and RND_SHIFT 1..35");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tap_cnt, tap_nxt;
  logic [2:0]    flag_sr;
  logic          accept;
  logic          last_beat;
  logic [7:0]    opmode_nxt;
  logic [47:0]   result;

  assign DSP_RST = RST;
  assign DSP_CE  = 1'b1;

`ifdef DSP_MAC_ROUND_EN
  assign DSP_C  = 48'h1 << (RND_SHIFT - 1);
  assign result = DSP_P >> RND_SHIFT;
`else
  assign DSP_C  = '0;
  assign result = DSP_P;
`endif

  // Only the last beat can stall: it must not launch a capture while the
  // previous result is still held or still travelling through the slice.
  always_comb begin
    s_ready   = !RST && !(tap_cnt == LAST_TAP && (m_valid || (|flag_sr)));
    accept    = s_valid && s_ready;
    last_beat = accept && (tap_cnt == LAST_TAP);
    DSP_A     = accept ? s_a : '0;
    DSP_B     = accept ? s_b : '0;
  end

  always_comb begin
    state_nxt  = state;
    tap_nxt    = tap_cnt;
    opmode_nxt = OPM_BUBBLE;
    if (accept) begin
      opmode_nxt = (state == IDLE) ? OPM_FIRST : OPM_TAP;
      if (last_beat) begin
        tap_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        tap_nxt   = tap_cnt + 1'b1;
        state_nxt = ACCUM;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      flag_sr    <= '0;
      DSP_OPMODE <= OPM_BUBBLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      state      <= state_nxt;
      tap_cnt    <= tap_nxt;
      flag_sr    <= {flag_sr[1:0], last_beat};
      DSP_OPMODE <= opmode_nxt;
      // The flag leaves the shift register the cycle the frame total sits on P.
      if (flag_sr[2]) begin
        m_valid <= 1'b1;
        m_data  <= result;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dsp_mac_ctrl.md
# dsp_mac_ctrl

Streaming dot-product sequencer that drives the control and operand ports of one DSP48A1 slice (default build: A0REG=0, A1REG=1, B0REG=0, B1REG=1, CREG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5", RSTTYPE="SYNC"). It accepts operand pairs over a valid/ready stream, issues per-beat OPMODE words aligned to the slice pipeline, and captures the accumulated P into a one-entry result register once every TAPS beats. It is the initiator side of the slice's operand/OPMODE interface.

## Interface
Parameters:
- TAPS, 8: operand pairs per frame (2..256).
- RND_SHIFT, 8: right shift applied to result when DSP_MAC_ROUND_EN is defined (1..35).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when s_valid & s_ready.
- s_a  in  18  unsigned multiplicand.
- s_b  in  18  unsigned multiplier.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_data  out  48  frame result.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B.
- DSP_C  out  48  to slice C.
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_CE  out  1  to all slice CE inputs.
- DSP_RST  out  1  to all slice RST inputs.
- DSP_P  in  48  from slice P.

## Operation
- DSP_RST = RST; DSP_CE = 1 always (no CE gating; stalls become zero bubbles). DSP_OPMODE[7:2] bits 4,5,6,7 are always 0 (pre-adder bypassed, carry-in 0, add).
- Per cycle t, the issue stage produces one op: accepted beat -> DSP_A=s_a, DSP_B=s_b; otherwise bubble -> DSP_A=DSP_B=0.
- OPMODE for op at t is driven at t+1 (one register stage): first tap 8'b0000_0001 (X=M, Z=0); other taps 8'b0000_1001 (X=M, Z=P); bubble 8'b0000_1000 (X=0, Z=P, holds P). Reset value of the OPMODE register: 8'b0000_1000.
- Tap counter tap_cnt 0..TAPS-1, increments per accepted beat, wraps to 0 after TAPS-1. tap_cnt==0 marks first tap. Two states: IDLE (tap_cnt==0) and ACCUM (tap_cnt!=0).
- Last beat (tap_cnt==TAPS-1) pushes a flag into a 3-deep shift register; when the flag exits (t+3), m_data <= result(DSP_P), m_valid <= 1.
- s_ready = !RST && !(tap_cnt==TAPS-1 && (m_valid || flag in flight)). Non-last beats never stall; a new frame may start the cycle after a last beat.
- m_valid cleared on m_valid & m_ready; capture and consume never coincide (guaranteed by s_ready rule).
- Arithmetic: unsigned 36-bit products, 48-bit accumulation; TAPS<=256 cannot overflow.

## Timing
- Reset values: s_ready=0 during RST, m_valid=0, m_data=0, DSP_A=DSP_B=0, DSP_OPMODE=8'h08, DSP_CE=1, tap_cnt=0, flags cleared.
- Operand at t -> A1/B1 at t+1 -> M at t+2 -> P visible t+3.
- Latency: last beat accepted at t -> m_valid high at t+4 (P sampled at t+3, registered).
- New frame's first product reaches P at its t'+3 >= t+4, so the sample at t+3 sees only the previous frame.
- RST mid-frame: partial frame discarded, slice cleared in the same cycle, no m_valid for it.

## Configuration
- DSP_MAC_ROUND_EN defined: DSP_C = 48'h1 << (RND_SHIFT-1) constant; first-tap OPMODE = 8'b0000_1101 (X=M, Z=C); m_data = DSP_P >> RND_SHIFT (logical, zero-filled).
- Undefined: DSP_C = 0; first-tap OPMODE = 8'b0000_0001; m_data = DSP_P.

## Test plan
- TAPS=8, 8 back-to-back beats a=1..8, b=2 -> m_valid 4 cycles after last, m_data=72, exactly one result.
- Same frame with s_valid low for 3 cycles after beat 4 -> bubble OPMODE 8'h08 seen, m_data=72.
- Two frames back-to-back (a=b=3 then a=b=18'h3FFFF), m_ready=1 -> results 72 and 8*(2^18-1)^2 = 48'h7_FFFC_0000_8.
- m_ready held low after first result -> s_ready drops at tap 7 of frame 2, frame 2 last beat waits until after m_ready pulse; both results correct, none lost.
- RST asserted at tap 5, then a full frame a=b=1 -> m_data=8, no result from aborted frame.
- With DSP_MAC_ROUND_EN, RND_SHIFT=4, a=b=10 x8 -> (800+8)>>4 = 50.
